// File: rtl/sha256_msg_sequencer.sv
// sha256_msg_sequencer: feeds padded 512-bit blocks to a single SHA-256
// compression core, chains intermediate hashes and returns the final digest.
module sha256_msg_sequencer #(
  parameter int unsigned  MAX_BLOCKS = 8,
  parameter int unsigned  TIMEOUT    = 128,
  parameter logic [255:0] IV         = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 blk_valid,
  output logic                                 blk_ready,
  input  logic [511:0]                         blk_data,
  input  logic                                 blk_last,
  input  logic                                 use_mid,
  input  logic [255:0]                         mid_hash,
  output logic                                 digest_valid,
  input  logic                                 digest_ready,
  output logic [255:0]                         digest,
  output logic [$clog2(MAX_BLOCKS+1)-1:0]      block_count,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic                                 len_err,
  output logic                                 core_enable,
  output logic [511:0]                         core_data,
  output logic [255:0]                         core_hash_in,
  input  logic [255:0]                         core_hash,
  input  logic                                 core_done
);

  localparam int unsigned CNT_W = $clog2(MAX_BLOCKS + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_NEXT,
    ST_OUT
  } state_e;

  state_e             state_q, state_d;
  logic               core_enable_q, core_enable_d;
  logic [511:0]       core_data_q, core_data_d;
  logic [255:0]       core_hash_in_q, core_hash_in_d;
  logic [255:0]       chain_q, chain_d;
  logic [255:0]       digest_q, digest_d;
  logic               digest_valid_q, digest_valid_d;
  logic [CNT_W-1:0]   block_count_q, block_count_d;
  logic               last_q, last_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               prev_done_q;
  logic               timeout_err_q, timeout_err_d;
  logic               len_err_q, len_err_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               completion;
  logic [CNT_W-1:0]   count_n;

  // Ready is decoded from state and forced low while reset is applied
  assign blk_ready  = ~rst & ((state_q == ST_IDLE) | (state_q == ST_NEXT));
  assign accept     = blk_valid & blk_ready;
  // Only a fresh rising edge of the done level counts as a completion
  assign completion = core_done & ~prev_done_q;
  assign count_n    = (state_q == ST_IDLE) ? CNT_W'(1) : block_count_q + CNT_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d        = state_q;
    core_enable_d  = 1'b0;
    core_data_d    = core_data_q;
    core_hash_in_d = core_hash_in_q;
    chain_d        = chain_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;
    block_count_d  = block_count_q;
    last_d         = last_q;
    timer_d        = timer_q;
    timeout_err_d  = timeout_err_q;
    len_err_d      = len_err_q;

    case (state_q)
      ST_IDLE, ST_NEXT: begin
        if (accept) begin
          core_data_d    = blk_data;
          core_hash_in_d = (state_q == ST_IDLE) ? (use_mid ? mid_hash : IV) : chain_q;
          block_count_d  = count_n;
          last_d         = blk_last;
          // The block that fills the message budget is forced to be last
          if (!blk_last && (count_n == CNT_W'(MAX_BLOCKS))) begin
            last_d    = 1'b1;
            len_err_d = 1'b1;
          end
          core_enable_d  = 1'b1;
          state_d        = ST_START;
        end
      end

      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (completion) begin
          chain_d = core_hash;
          if (last_q) begin
            digest_d       = core_hash;
            digest_valid_d = 1'b1;
            state_d        = ST_OUT;
          end else begin
            state_d        = ST_NEXT;
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_OUT: begin
        if (digest_ready) begin
          digest_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      core_enable_q  <= 1'b0;
      core_data_q    <= '0;
      core_hash_in_q <= '0;
      chain_q        <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      block_count_q  <= '0;
      last_q         <= 1'b0;
      timer_q        <= '0;
      prev_done_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      len_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      core_enable_q  <= core_enable_d;
      core_data_q    <= core_data_d;
      core_hash_in_q <= core_hash_in_d;
      chain_q        <= chain_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      block_count_q  <= block_count_d;
      last_q         <= last_d;
      timer_q        <= timer_d;
      prev_done_q    <= core_done;
      timeout_err_q  <= timeout_err_d;
      len_err_q      <= len_err_d;
      busy_q         <= busy_d;
    end
  end

  assign core_enable  = core_enable_q;
  assign core_data    = core_data_q;
  assign core_hash_in = core_hash_in_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign block_count  = block_count_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer with a behavioural SHA-256 core.
module tb_sha256_msg_sequencer;

  localparam logic [255:0] IV_C  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ZERO64 = 256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_last = 1'b0;
  logic         use_mid = 1'b0;
  logic [255:0] mid_hash = '0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [255:0] digest;
  logic [3:0]   block_count;
  logic         busy;
  logic         timeout_err;
  logic         len_err;
  logic         core_enable;
  logic [511:0] core_data;
  logic [255:0] core_hash_in;
  logic [255:0] core_hash = '0;
  logic         core_done = 1'b0;

  int tests = 0;
  int fails = 0;

  sha256_msg_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .use_mid      (use_mid),
    .mid_hash     (mid_hash),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest),
    .block_count  (block_count),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .len_err      (len_err),
    .core_enable  (core_enable),
    .core_data    (core_data),
    .core_hash_in (core_hash_in),
    .core_hash    (core_hash),
    .core_done    (core_done)
  );

  always #5 clk = ~clk;

  // Reference SHA-256 compression (with feed-forward)
  logic [2047:0] k_all = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hin[255:224]; b = hin[223:192]; c = hin[191:160]; d = hin[159:128];
    e = hin[127:96];  f = hin[95:64];   g = hin[63:32];   h = hin[31:0];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_all[2047-32*i -: 32] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,   hin[31:0] + h};
  endfunction

  // Behavioural core: done is a level that drops on each new start
  logic         hang = 1'b0;
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  logic [255:0] m_res = '0;
  int           n_en = 0;
  logic [255:0] hin_log [16];
  logic [255:0] res_log [16];

  always @(posedge clk) begin
    if (rst) begin
      core_done <= 1'b0;
      m_busy    <= 1'b0;
      m_cnt     <= 0;
    end else if (core_enable) begin
      core_done            <= 1'b0;
      hin_log[n_en % 16]   <= core_hash_in;
      res_log[n_en % 16]   <= sha_compress(core_hash_in, core_data);
      m_res                <= sha_compress(core_hash_in, core_data);
      n_en                 <= n_en + 1;
      m_busy               <= ~hang;
      m_cnt                <= LAT;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        core_done <= 1'b1;
        core_hash <= m_res;
        m_busy    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block from a negedge; returns at the negedge of the start cycle
  task automatic send_block(input logic [511:0] d, input logic last,
                            input logic um, input logic [255:0] mh);
    int g;
    g = 0;
    blk_data = d; blk_last = last; use_mid = um; mid_hash = mh; blk_valid = 1'b1;
    while (!blk_ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("blk_accept", 256'(blk_ready), 256'(1));
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic wait_digest();
    int g;
    g = 0;
    while (!digest_valid && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("digest_valid_wait", 256'(digest_valid), 256'(1));
  endtask

  task automatic handshake();
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("hs_dv_clear", 256'(digest_valid), 256'(0));
    chk("hs_idle", 256'({busy, blk_ready}), 256'(2'b01));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] b_empty, b_abc, b_zero, b_pad;
    int base, g, en_snap;
    logic ok;

    b_empty = '0; b_empty[511] = 1'b1;
    b_abc = '0; b_abc[511:488] = 24'h616263; b_abc[487] = 1'b1; b_abc[63:0] = 64'd24;
    b_zero = '0;
    b_pad = '0; b_pad[511] = 1'b1; b_pad[63:0] = 64'd512;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_blk_ready", 256'(blk_ready), 256'(0));
    chk("rst_flags", 256'({digest_valid, core_enable, busy, timeout_err, len_err}), 256'(0));
    chk("rst_count", 256'(block_count), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 256'(blk_ready), 256'(1));

    // Empty string, single block from IV
    base = n_en;
    send_block(b_empty, 1'b1, 1'b0, '0);
    chk("empty_en_pulse", 256'({core_enable, busy, blk_ready}), 256'(3'b110));
    chk("empty_hash_in", core_hash_in, IV_C);
    @(negedge clk);
    chk("empty_en_drop", 256'(core_enable), 256'(0));
    wait_digest();
    chk("empty_digest", digest, D_EMPTY);
    chk("empty_count", 256'(block_count), 256'(1));
    chk("empty_en_count", 256'(n_en - base), 256'(1));
    handshake();

    // "abc"
    send_block(b_abc, 1'b1, 1'b0, '0);
    wait_digest();
    chk("abc_digest", digest, D_ABC);
    handshake();

    // Two blocks with chaining, then hold the digest under backpressure
    base = n_en;
    send_block(b_zero, 1'b0, 1'b0, '0);
    send_block(b_pad, 1'b1, 1'b0, '0);
    wait_digest();
    chk("two_chain", hin_log[(base + 1) % 16], res_log[base % 16]);
    chk("two_digest", digest, D_ZERO64);
    chk("two_count", 256'(block_count), 256'(2));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ok = digest_valid && (digest == D_ZERO64) && !blk_ready && busy;
      chk("bp_hold", 256'(ok), 256'(1));
    end
    handshake();

    // Core never finishes: abort on timeout
    hang = 1'b1;
    send_block(b_abc, 1'b1, 1'b0, '0);
    repeat (120) @(negedge clk);
    chk("to_pending", 256'({timeout_err, busy}), 256'(2'b01));
    g = 0;
    while (!timeout_err && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("to_err", 256'({timeout_err, busy, digest_valid}), 256'(3'b100));
    hang = 1'b0;
    send_block(b_abc, 1'b1, 1'b0, '0);
    wait_digest();
    chk("to_abc_digest", digest, D_ABC);
    chk("to_sticky", 256'(timeout_err), 256'(1));
    handshake();

    // Reset while waiting on the core
    send_block(b_empty, 1'b1, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_flags", 256'({digest_valid, core_enable, busy, timeout_err, len_err, blk_ready}), 256'(0));
    chk("wrst_regs", 256'({block_count, digest != '0, core_data != '0, core_hash_in != '0}), 256'(0));
    rst = 1'b0;
    en_snap = n_en;
    repeat (10) @(negedge clk);
    chk("wrst_quiet", 256'({digest_valid, busy}), 256'(0));
    chk("wrst_no_enable", 256'(n_en - en_snap), 256'(0));

    // Midstate equal to IV reproduces the empty-string digest
    send_block(b_empty, 1'b1, 1'b1, IV_C);
    chk("mid_hash_in", core_hash_in, IV_C);
    wait_digest();
    chk("mid_digest", digest, D_EMPTY);
    handshake();

    // Block budget exhausted without a last flag
    for (int i = 0; i < 8; i++) send_block(b_zero, 1'b0, 1'b0, '0);
    chk("len_count", 256'(block_count), 256'(8));
    chk("len_err", 256'(len_err), 256'(1));
    wait_digest();
    chk("len_digest", digest, res_log[(n_en - 1) % 16]);
    chk("len_out_ready", 256'(blk_ready), 256'(0));
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Control block that drives one sha256 compression core across a multi-block message. It accepts 512-bit padded blocks over a valid/ready stream and issues a one-cycle start pulse to the core per block. It chains each intermediate hash into the next block and returns the final 256-bit digest over a valid/ready output. It sits between the Scrypt/PBKDF2 front end and the sha256 core, and is the only master of the core's enable, data and current_hash inputs.

Parameters:
MAX_BLOCKS, 8, maximum blocks per message; block_count width is clog2(MAX_BLOCKS+1).
TIMEOUT, 128, cycles allowed from core start to core done before abort.
IV, {6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19}, default initial hash (256 bits).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
blk_valid  in  1  input block valid
blk_ready  out  1  sequencer accepts a block this cycle
blk_data  in  512  padded message block, bit 511 = first message bit
blk_last  in  1  block is final block of message
use_mid  in  1  sampled with first block; 1 = start from mid_hash instead of IV
mid_hash  in  256  precomputed midstate, sampled with first block
digest_valid  out  1  final digest available
digest_ready  in  1  consumer takes digest
digest  out  256  final hash
block_count  out  clog2(MAX_BLOCKS+1)  blocks accepted in current message
busy  out  1  message in progress (not IDLE)
timeout_err  out  1  sticky, core did not finish within TIMEOUT
len_err  out  1  sticky, message exceeded MAX_BLOCKS
core_enable  out  1  one-cycle start pulse to core
core_data  out  512  block to core, held stable until core done
core_hash_in  out  256  chaining value to core, held stable until core done
core_hash  in  256  core result (feed-forward addition already applied)
core_done  in  1  core done flag (level)

Behaviour:
- All outputs registered except blk_ready, which is decoded from state.
- While rst=1, all registers clear on the clock edge: state=IDLE; core_enable, core_data, core_hash_in, digest, digest_valid, block_count, timeout_err and len_err are 0.
- blk_ready=0 during the reset cycle.
- rst mid-message aborts immediately. No digest is produced, and the core is not re-enabled.
- States: IDLE, START, WAIT, NEXT, OUT.
- blk_ready=1 only in IDLE and NEXT.
- IDLE, on accept (blk_valid & blk_ready):
  - core_data <= blk_data.
  - core_hash_in <= use_mid ? mid_hash : IV.
  - Latch blk_last; block_count <= 1; go to START.
- NEXT, on accept: core_data <= blk_data; core_hash_in <= chain register; block_count+1; go to START.
- START: core_enable=1 for exactly this one cycle, i.e. the cycle after accept. Timer cleared; go to WAIT.
- WAIT:
  - core_enable=0.
  - A completion is a rising edge of core_done (core_done=1 while prev_done=0). A level left high from the previous block is ignored.
  - On completion, chain <= core_hash.
  - If the latched last flag is set: digest <= core_hash, digest_valid <= 1, go to OUT.
  - Otherwise go to NEXT.
- Timeout: if the timer reaches TIMEOUT-1 in WAIT with no completion, set timeout_err, return to IDLE, and discard the message.
- OUT: digest_valid held, and digest held stable, until digest_ready=1. On that handshake clear digest_valid and go to IDLE.
  - blk_ready=0 in OUT; the next message is accepted one cycle after the handshake, at the earliest.
- Length limit: if block MAX_BLOCKS is accepted with blk_last=0, it is treated as last and len_err is set. The digest is still produced.
- Latency: accept at edge N, core_enable high in cycle N+1. A completion sampled at edge M gives digest_valid=1 from edge M (visible cycle M+1).
- busy=1 in every state except IDLE.
- timeout_err and len_err are cleared only by rst.

Test Plan:
- Empty string: one block with bit 511=1, rest 0, last=1, use_mid=0 -> digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; block_count=1; exactly one core_enable pulse.
- "abc": blk_data[511:488]=616263, bit 487=1, [63:0]=24, last=1 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Two blocks: 512 zero bits (last=0), then pad block with bit 511=1 and [63:0]=512 (last=1) -> second core_hash_in equals the first core_hash; digest f5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b; block_count=2.
- Backpressure: digest_ready=0 for 10 cycles after digest_valid -> digest_valid and digest stable, blk_ready=0 throughout; handshake -> IDLE next cycle.
- Timeout: core model never raises core_done -> timeout_err=1 TIMEOUT cycles after core_enable, busy=0, no digest_valid. A following "abc" message completes correctly with timeout_err still 1.
- Reset and midstate:
  - rst asserted in WAIT -> next cycle state IDLE, all outputs 0, no digest.
  - Then use_mid=1 with mid_hash=IV on the empty-string block -> same digest as the first scenario.
